apu_frame_sequencer: RTL and testbench

// - Frame sequencer for the APU square channels: divides APU ticks into quarter/half-frame events and raises a frame IRQ.
// - Drives the sweep clock into the frequency block through a per-channel sweep divider.
// - Sits between the CPU register interface and the channel datapaths: frequency, envelope and length counter.

---
 rtl/apu_pkg.sv | 52 +++++
 rtl/sweep_divider.sv | 67 ++++++
 rtl/apu_frame_sequencer.sv | 124 ++++++++++++
 tb/tb_apu_frame_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared constants and step-table helpers for the APU frame sequencer.
// The step table is a per-(mode, step) event mask of quarter/half/IRQ bits.
package apu_pkg;

  localparam logic MODE_4STEP = 1'b0;
  localparam logic MODE_5STEP = 1'b1;

  localparam logic [2:0] STEPS_4 = 3'd4;
  localparam logic [2:0] STEPS_5 = 3'd5;

  localparam int DIV_DEFAULT = 7457;

  localparam int MASK_Q   = 0;
  localparam int MASK_H   = 1;
  localparam int MASK_IRQ = 2;

  typedef logic [2:0] stepMask_t;

  localparam stepMask_t EV_NONE = 3'b000;
  localparam stepMask_t EV_Q    = 3'b001;
  localparam stepMask_t EV_QH   = 3'b011;
  localparam stepMask_t EV_QHI  = 3'b111;

  function automatic stepMask_t stepMask(input logic mode, input logic [2:0] step);
    stepMask_t m;
    m = EV_NONE;
    if (mode == MODE_4STEP) begin
      case (step)
        3'd0:    m = EV_Q;
        3'd1:    m = EV_QH;
        3'd2:    m = EV_Q;
        3'd3:    m = EV_QHI;
        default: m = EV_NONE;
      endcase
    end else begin
      case (step)
        3'd0:    m = EV_Q;
        3'd1:    m = EV_QH;
        3'd2:    m = EV_Q;
        3'd3:    m = EV_NONE;
        3'd4:    m = EV_QH;
        default: m = EV_NONE;
      endcase
    end
    return m;
  endfunction

  function automatic logic [2:0] lastStep(input logic mode);
    return (mode == MODE_5STEP) ? (STEPS_5 - 3'd1) : (STEPS_4 - 3'd1);
  endfunction

endpackage

// File: rtl/sweep_divider.sv
// Per-channel sweep divider: turns half-frame events into sweep clock pulses
// every (period+1) halves, with a reload requested by each config write.
module sweep_divider
  import apu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iHalf,
  input  logic       iSweep_wr,
  input  logic [2:0] iSweep_period,
  input  logic       iSweep_enable,
  output logic       oSweep_clk
);

  logic [2:0] cnt_r, cnt_s;
  logic [2:0] period_r, period_s;
  logic       en_r, en_s;
  logic       reload_r, reload_s;
  logic       sweepClk_r, sweepClk_s;

  // Next-state: a half event uses the old config; a same-cycle write still arms reload.
  always_comb begin
    cnt_s      = cnt_r;
    period_s   = period_r;
    en_s       = en_r;
    reload_s   = reload_r;
    sweepClk_s = 1'b0;
    if (iHalf) begin
      sweepClk_s = (cnt_r == 3'd0) && en_r;
      if ((cnt_r == 3'd0) || reload_r) begin
        cnt_s    = period_r;
        reload_s = 1'b0;
      end else begin
        cnt_s = cnt_r - 3'd1;
      end
    end else begin
      sweepClk_s = 1'b0;
    end
    if (iSweep_wr) begin
      period_s = iSweep_period;
      en_s     = iSweep_enable;
      reload_s = 1'b1;
    end else begin
      reload_s = reload_s;
    end
  end

  // Divider state and registered sweep pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= 3'd0;
      period_r   <= 3'd0;
      en_r       <= 1'b0;
      reload_r   <= 1'b0;
      sweepClk_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_s;
      period_r   <= period_s;
      en_r       <= en_s;
      reload_r   <= reload_s;
      sweepClk_r <= sweepClk_s;
    end
  end

  assign oSweep_clk = sweepClk_r;

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: divides APU ticks into quarter/half-frame events,
// raises the frame IRQ, and drives the sweep divider from half events.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int DIV_W = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iTick,
  input  logic       iWr,
  input  logic       iWr_mode,
  input  logic       iWr_irq_inhibit,
  input  logic       iIrq_ack,
  input  logic       iSweep_wr,
  input  logic [2:0] iSweep_period,
  input  logic       iSweep_enable,
  output logic       oQuarter,
  output logic       oHalf,
  output logic       oSweep_clk,
  output logic       oIrq,
  output logic [2:0] oStep
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] divCnt_r, divCnt_s;
  logic [2:0]       step_r, step_s;
  logic             mode_r, mode_s;
  logic             inhibit_r, inhibit_s;
  logic             quarter_r, quarter_s;
  logic             half_r, half_s;
  logic             irq_r, irq_s;
  logic             stepEvent_s;
  stepMask_t        mask_s;

  // State register: sequencer state plus the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCnt_r  <= '0;
      step_r    <= 3'd0;
      mode_r    <= MODE_4STEP;
      inhibit_r <= 1'b0;
      quarter_r <= 1'b0;
      half_r    <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      divCnt_r  <= divCnt_s;
      step_r    <= step_s;
      mode_r    <= mode_s;
      inhibit_r <= inhibit_s;
      quarter_r <= quarter_s;
      half_r    <= half_s;
      irq_r     <= irq_s;
    end
  end

  // Next-state: a register write restarts the frame and swallows any same-cycle tick.
  always_comb begin
    divCnt_s    = divCnt_r;
    step_s      = step_r;
    mode_s      = mode_r;
    inhibit_s   = inhibit_r;
    stepEvent_s = 1'b0;
    if (iWr) begin
      mode_s    = iWr_mode;
      inhibit_s = iWr_irq_inhibit;
      divCnt_s  = '0;
      step_s    = 3'd0;
    end else if (iTick) begin
      if (divCnt_r == DIV_LAST) begin
        divCnt_s    = '0;
        stepEvent_s = 1'b1;
        step_s      = (step_r >= lastStep(mode_r)) ? 3'd0 : (step_r + 3'd1);
      end else begin
        divCnt_s = divCnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end else begin
      divCnt_s = divCnt_r;
    end
  end

  // Output decode: pulses for the step being left; IRQ set beats acknowledge.
  always_comb begin
    mask_s    = stepMask(mode_r, step_r);
    quarter_s = 1'b0;
    half_s    = 1'b0;
    irq_s     = irq_r;
    if (stepEvent_s) begin
      quarter_s = mask_s[MASK_Q];
      half_s    = mask_s[MASK_H];
    end else if (iWr) begin
      quarter_s = iWr_mode;
      half_s    = iWr_mode;
    end else begin
      quarter_s = 1'b0;
      half_s    = 1'b0;
    end
    if (stepEvent_s && mask_s[MASK_IRQ] && !inhibit_r) begin
      irq_s = 1'b1;
    end else if (iIrq_ack || (iWr && iWr_irq_inhibit)) begin
      irq_s = 1'b0;
    end else begin
      irq_s = irq_r;
    end
  end

  sweep_divider uSweep (
    .clk           (clk),
    .rst_n         (rst_n),
    .iHalf         (half_s),
    .iSweep_wr     (iSweep_wr),
    .iSweep_period (iSweep_period),
    .iSweep_enable (iSweep_enable),
    .oSweep_clk    (oSweep_clk)
  );

  assign oQuarter = quarter_r;
  assign oHalf    = half_r;
  assign oIrq     = irq_r;
  assign oStep    = step_r;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Randomized self-checking bench for apu_frame_sequencer (DIV=4) against a
// tick-counting reference model of the frame sequence and sweep divider.
module tb_apu_frame_sequencer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, wr = 1'b0, wrMode = 1'b0, wrInh = 1'b0, ack = 1'b0;
  logic       swr = 1'b0, sen = 1'b0;
  logic [2:0] sp = 3'd0;
  logic       oQuarter, oHalf, oSweep_clk, oIrq;
  logic [2:0] oStep;

  int tests = 0;
  int failed = 0;

  // Reference model state: ticks since the last frame restart drive everything.
  int   mTicks, mSwCnt, mSwPer;
  bit   mMode, mInh, mIrq, mSwEn, mSwRel;
  bit   expQ, expH, expSw, expIrq;
  int   expStep;

  apu_frame_sequencer #(.DIV(DIV), .DIV_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .iTick(tick), .iWr(wr), .iWr_mode(wrMode),
    .iWr_irq_inhibit(wrInh), .iIrq_ack(ack), .iSweep_wr(swr),
    .iSweep_period(sp), .iSweep_enable(sen),
    .oQuarter(oQuarter), .oHalf(oHalf), .oSweep_clk(oSweep_clk),
    .oIrq(oIrq), .oStep(oStep)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mTicks = 0; mSwCnt = 0; mSwPer = 0;
    mMode = 0; mInh = 0; mIrq = 0; mSwEn = 0; mSwRel = 0;
    expQ = 0; expH = 0; expSw = 0; expIrq = 0; expStep = 0;
  endtask

  task automatic modelUpdate();
    bit q, h, sw, irqSet;
    int n, ev;
    q = 0; h = 0; sw = 0; irqSet = 0;
    if (wr) begin
      mMode = wrMode; mInh = wrInh; mTicks = 0;
      q = wrMode; h = wrMode;
    end else if (tick) begin
      mTicks++;
      if (mTicks % DIV == 0) begin
        n = mMode ? 5 : 4;
        ev = (mTicks / DIV - 1) % n;
        if (!mMode) begin
          q = 1; h = (ev % 2 == 1); irqSet = (ev == 3) && !mInh;
        end else begin
          q = (ev != 3); h = (ev == 1 || ev == 4);
        end
      end
    end
    if (irqSet) mIrq = 1;
    else if (ack || (wr && wrInh)) mIrq = 0;
    if (h) begin
      if (mSwCnt == 0 && mSwEn) sw = 1;
      if (mSwCnt == 0 || mSwRel) begin mSwCnt = mSwPer; mSwRel = 0; end
      else mSwCnt--;
    end
    if (swr) begin mSwPer = sp; mSwEn = sen; mSwRel = 1; end
    expQ = q; expH = h; expSw = sw; expIrq = mIrq;
    expStep = (mTicks / DIV) % (mMode ? 5 : 4);
  endtask

  // Advance one clock: model follows the DUT edge, outputs settle by the negedge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) modelReset(); else modelUpdate();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    tick = 0; wr = 0; wrMode = 0; wrInh = 0; ack = 0; swr = 0; sen = 0; sp = 3'd0;
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    doReset();
    tests++;
    if ({oQuarter, oHalf, oSweep_clk, oIrq, oStep} !== 7'd0) begin
      failed++;
      $display("FAIL reset: outputs=%b required 0", {oQuarter, oHalf, oSweep_clk, oIrq, oStep});
    end
  endtask

  task automatic test_four_step();
    doReset();
    tick = 1;
    for (int i = 1; i <= 24; i++) begin
      step();
      tests++;
      if (oQuarter !== expQ || oHalf !== expH || oIrq !== expIrq || oStep !== expStep[2:0]) begin
        failed++;
        $display("FAIL four_step cyc%0d: Q%b H%b I%b S%0d required Q%b H%b I%b S%0d",
                 i, oQuarter, oHalf, oIrq, oStep, expQ, expH, expIrq, expStep);
      end
      if (i == 16) begin
        tests++;
        if (oIrq !== 1'b1) begin failed++; $display("FAIL irq_rise: oIrq=%b required 1", oIrq); end
      end
    end
    tick = 0; ack = 1;
    step();
    ack = 0;
    tests++;
    if (oIrq !== 1'b0) begin failed++; $display("FAIL irq_ack: oIrq=%b required 0", oIrq); end
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 400; i++) begin
      tick = 1'($urandom_range(0, 3) != 0);
      ack = 1'($urandom_range(0, 15) == 0);
      wr = 1'($urandom_range(0, 63) == 0);
      wrMode = 1'($urandom_range(0, 1));
      wrInh = 1'($urandom_range(0, 3) == 0);
      swr = 1'($urandom_range(0, 31) == 0);
      sp = 3'($urandom_range(0, 7));
      sen = 1'($urandom_range(0, 1));
      step();
      tests++;
      if (oQuarter !== expQ || oHalf !== expH || oIrq !== expIrq ||
          oSweep_clk !== expSw || oStep !== expStep[2:0]) begin
        failed++;
        $display("FAIL random cyc%0d: Q%b H%b SW%b I%b S%0d required Q%b H%b SW%b I%b S%0d",
                 i, oQuarter, oHalf, oSweep_clk, oIrq, oStep, expQ, expH, expSw, expIrq, expStep);
      end
    end
    idleInputs();
  endtask

  task automatic test_five_step();
    int irqSeen;
    doReset();
    wr = 1; wrMode = 1;
    step();
    wr = 0; wrMode = 0;
    tests++;
    if (oQuarter !== 1'b1 || oHalf !== 1'b1) begin
      failed++; $display("FAIL five_wr: Q%b H%b required Q1 H1", oQuarter, oHalf);
    end
    irqSeen = 0;
    for (int i = 0; i < 60; i++) begin
      tick = 1'($urandom_range(0, 1));
      step();
      if (oIrq) irqSeen++;
      tests++;
      if (oQuarter !== expQ || oHalf !== expH || oStep !== expStep[2:0]) begin
        failed++;
        $display("FAIL five_step cyc%0d: Q%b H%b S%0d required Q%b H%b S%0d",
                 i, oQuarter, oHalf, oStep, expQ, expH, expStep);
      end
    end
    tests++;
    if (irqSeen != 0) begin failed++; $display("FAIL five_irq: irq cycles=%0d required 0", irqSeen); end
    idleInputs();
  endtask

  task automatic test_inhibit();
    int guard, irqSeen;
    doReset();
    tick = 1;
    guard = 0;
    while (oIrq !== 1'b1 && guard < 40) begin step(); guard++; end
    tests++;
    if (oIrq !== 1'b1) begin failed++; $display("FAIL inhibit_setup: oIrq=%b required 1", oIrq); end
    tick = 0; wr = 1; wrInh = 1;
    step();
    wr = 0; wrInh = 0;
    tests++;
    if (oIrq !== 1'b0) begin failed++; $display("FAIL inhibit_clear: oIrq=%b required 0", oIrq); end
    tick = 1; irqSeen = 0;
    for (int i = 0; i < 48; i++) begin step(); if (oIrq !== 1'b0) irqSeen++; end
    tests++;
    if (irqSeen != 0) begin failed++; $display("FAIL inhibit_hold: irq cycles=%0d required 0", irqSeen); end
    idleInputs();
  endtask

  task automatic test_sweep();
    int halves, pulses, mism;
    int got[$];
    doReset();
    swr = 1; sp = 3'd2; sen = 1;
    step();
    swr = 0;
    tick = 1; halves = 0; mism = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (oHalf) halves++;
      if (oSweep_clk) got.push_back(halves);
      if (oSweep_clk !== expSw || oHalf !== oSweep_clk && oSweep_clk) mism++;
    end
    tests++;
    if (mism != 0) begin failed++; $display("FAIL sweep_model: mismatched cycles=%0d required 0", mism); end
    tests++;
    if (got.size() != 3 || got[0] != 1 || got[1] != 4 || got[2] != 7) begin
      failed++; $display("FAIL sweep_halves: got %p required '{1,4,7}", got);
    end
    swr = 1; sp = 3'($urandom_range(0, 7)); sen = 0;
    step();
    swr = 0; pulses = 0;
    for (int i = 0; i < 120; i++) begin
      tick = 1'($urandom_range(0, 1));
      step();
      if (oSweep_clk !== 1'b0) pulses++;
    end
    tests++;
    if (pulses != 0) begin failed++; $display("FAIL sweep_disabled: pulses=%0d required 0", pulses); end
    idleInputs();
  endtask

  task automatic test_wr_collision();
    int n;
    doReset();
    tick = 1;
    for (int i = 0; i < 3; i++) step();
    wr = 1; wrMode = 0;
    step();
    wr = 0;
    tests++;
    if (oQuarter !== 1'b0 || oHalf !== 1'b0 || oStep !== 3'd0) begin
      failed++; $display("FAIL wr_collision: Q%b H%b S%0d required Q0 H0 S0", oQuarter, oHalf, oStep);
    end
    n = 0;
    do begin step(); n++; end while (oQuarter !== 1'b1 && n < 20);
    tests++;
    if (n != 4) begin failed++; $display("FAIL wr_collision_next: ticks=%0d required 4", n); end
    idleInputs();
  endtask

  task automatic test_async_reset();
    int guard, n;
    doReset();
    tick = 1;
    guard = 0;
    while (oIrq !== 1'b1 && guard < 40) begin step(); guard++; end
    step();
    step();
    #2 rst_n = 0;
    #1;
    tests++;
    if ({oQuarter, oHalf, oSweep_clk, oIrq, oStep} !== 7'd0) begin
      failed++;
      $display("FAIL async_reset: outputs=%b required 0", {oQuarter, oHalf, oSweep_clk, oIrq, oStep});
    end
    step();
    rst_n = 1;
    n = 0;
    do begin step(); n++; end while (oQuarter !== 1'b1 && n < 20);
    tests++;
    if (n != 4) begin failed++; $display("FAIL async_reset_next: ticks=%0d required 4", n); end
    idleInputs();
  endtask

  initial begin
    modelReset();
    @(negedge clk);
    test_reset();
    test_four_step();
    test_random();
    test_five_step();
    test_inhibit();
    test_sweep();
    test_wr_collision();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
